// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress: write-side ingress of the async FIFO; 2-entry skid buffer feeding
// the write controller, plus conservative fill level / almost-full from the synced read pointer.
`default_nettype none

module fifo_wr_ingress #(
  parameter int ADDRLEN   = 4,
  parameter int DWIDTH    = 8,
  parameter int AF_THRESH = 6
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               in_valid_i,
  input  logic [DWIDTH-1:0]  in_data_i,
  output logic               in_ready_o,
  input  logic               full_i,
  input  logic [ADDRLEN-1:0] syn_rptr_i,
  output logic               winc_o,
  output logic [DWIDTH-1:0]  wdata_o,
  output logic [ADDRLEN-1:0] wr_level_o,
  output logic               almost_full_o,
  output logic [1:0]         buf_count_o
);

  // State encoding doubles as the buffer occupancy.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [ADDRLEN-1:0] AF_LEVEL = ADDRLEN'(AF_THRESH);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [DWIDTH-1:0]  head;
  logic [DWIDTH-1:0]  skid;
  logic [ADDRLEN-1:0] wcnt;
  logic [ADDRLEN-1:0] wcnt_next;
  logic [ADDRLEN-1:0] rbin;
  logic [ADDRLEN-1:0] level_next;
  logic               push;
  logic               pop;

  assign winc_o      = (state != S_EMPTY) & ~full_i;
  assign wdata_o     = head;
  assign buf_count_o = state;
  assign pop         = winc_o;
  assign push        = in_valid_i & in_ready_o;

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (push) state_next = S_ONE;
      S_ONE: begin
        if (push & ~pop)      state_next = S_TWO;
        else if (pop & ~push) state_next = S_EMPTY;
      end
      S_TWO:   if (pop) state_next = S_ONE;
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= S_EMPTY;
      head       <= '0;
      skid       <= '0;
      in_ready_o <= 1'b0;
    end else begin
      state      <= state_next;
      // Ready is registered so full_i never reaches the producer combinationally.
      in_ready_o <= (state_next != S_TWO);
      case (state)
        S_EMPTY: if (push) head <= in_data_i;
        S_ONE: begin
          if (push & pop)       head <= in_data_i;
          else if (push & ~pop) skid <= in_data_i;
        end
        S_TWO:   if (pop) head <= skid;
        default: ;
      endcase
    end
  end

  always_comb begin
    rbin = '0;
    for (int i = 0; i < ADDRLEN; i++) begin
      rbin[i] = ^(syn_rptr_i >> i);
    end
  end

  // Modular subtraction handles pointer wrap; a stale read pointer only over-reports.
  assign wcnt_next  = wcnt + {{(ADDRLEN-1){1'b0}}, pop};
  assign level_next = wcnt_next - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wcnt          <= '0;
      wr_level_o    <= '0;
      almost_full_o <= 1'b0;
    end else begin
      wcnt          <= wcnt_next;
      wr_level_o    <= level_next;
      almost_full_o <= (level_next >= AF_LEVEL);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ingress.sv
// tb_fifo_wr_ingress: randomized + directed stimulus against a queue-based model of the
// write ingress, with per-cycle comparison and literal pins on key scenarios.
`default_nettype none

module tb_fifo_wr_ingress;

  localparam int ADDRLEN   = 4;
  localparam int DWIDTH    = 8;
  localparam int AF_THRESH = 6;
  localparam int PMOD      = 1 << ADDRLEN;

  logic               wclk = 1'b0;
  logic               wrst_n = 1'b0;
  logic               in_valid_i = 1'b0;
  logic [DWIDTH-1:0]  in_data_i = '0;
  logic               in_ready_o;
  logic               full_i = 1'b0;
  logic [ADDRLEN-1:0] syn_rptr_i = '0;
  logic               winc_o;
  logic [DWIDTH-1:0]  wdata_o;
  logic [ADDRLEN-1:0] wr_level_o;
  logic               almost_full_o;
  logic [1:0]         buf_count_o;

  int checks = 0;
  int errors = 0;

  fifo_wr_ingress #(.ADDRLEN(ADDRLEN), .DWIDTH(DWIDTH), .AF_THRESH(AF_THRESH)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .full_i(full_i), .syn_rptr_i(syn_rptr_i),
    .winc_o(winc_o), .wdata_o(wdata_o),
    .wr_level_o(wr_level_o), .almost_full_o(almost_full_o), .buf_count_o(buf_count_o)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: words waiting in a queue, read pointer held in binary.
  logic [DWIDTH-1:0] mq[$];
  bit m_ready, m_pop, m_push, m_af, exp_winc;
  int m_wcnt, m_rb, m_level;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mq.delete();
      m_ready = 0; m_wcnt = 0; m_level = 0; m_af = 0;
    end else begin
      m_pop  = (mq.size() > 0) && !full_i;
      m_push = in_valid_i && m_ready;
      if (m_pop) begin
        void'(mq.pop_front());
        m_wcnt = (m_wcnt + 1) % PMOD;
      end
      if (m_push) mq.push_back(in_data_i);
      m_ready = (mq.size() < 2);
      m_level = (m_wcnt - m_rb + PMOD) % PMOD;
      m_af    = (m_level >= AF_THRESH);
    end
  end

  always @(negedge wclk) begin
    if (wrst_n) begin
      exp_winc = (mq.size() > 0) && !full_i;
      check("in_ready", 32'(in_ready_o), 32'(m_ready));
      check("winc", 32'(winc_o), 32'(exp_winc));
      if (exp_winc && winc_o) check("wdata", 32'(wdata_o), 32'(mq[0]));
      check("buf_count", 32'(buf_count_o), 32'(mq.size()));
      check("wr_level", 32'(wr_level_o), 32'(m_level));
      check("almost_full", 32'(almost_full_o), 32'(m_af));
    end
  end

  // Every word written to the controller, in order.
  logic [DWIDTH-1:0] cap[$];
  always @(negedge wclk) if (wrst_n && winc_o) cap.push_back(wdata_o);

  function automatic logic [ADDRLEN-1:0] to_gray(input int b);
    logic [ADDRLEN-1:0] v;
    v = ADDRLEN'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_rptr(input int rb);
    m_rb       = rb;
    syn_rptr_i = to_gray(rb);
  endtask

  task automatic do_reset();
    in_valid_i = 0;
    full_i     = 0;
    set_rptr(0);
    @(negedge wclk);
    #1 wrst_n = 0;
    repeat (2) @(negedge wclk);
    #1 wrst_n = 1;
    tick();
  endtask

  initial begin
    int errs;
    bit rdy;
    bit got;
    logic [DWIDTH-1:0] exp3 [3];
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    m_rb = 0;

    // Reset state.
    repeat (2) @(negedge wclk);
    check("rst_winc", 32'(winc_o), 0);
    check("rst_ready", 32'(in_ready_o), 0);
    check("rst_buf", 32'(buf_count_o), 0);
    check("rst_level", 32'(wr_level_o), 0);
    check("rst_af", 32'(almost_full_o), 0);
    check("rst_wdata", 32'(wdata_o), 0);
    #1 wrst_n = 1;
    tick();
    check("ready_after_rst", 32'(in_ready_o), 1);

    // Single word.
    in_valid_i = 1; in_data_i = 8'hA5;
    tick();
    in_valid_i = 0;
    @(negedge wclk);
    check("single_winc", 32'(winc_o), 1);
    check("single_wdata", 32'(wdata_o), 32'h A5);
    check("single_buf", 32'(buf_count_o), 1);
    tick();
    @(negedge wclk);
    check("single_winc_off", 32'(winc_o), 0);
    check("single_buf_off", 32'(buf_count_o), 0);
    check("single_level", 32'(wr_level_o), 1);

    // Streaming 20 words, read pointer pinned at 0.
    do_reset();
    cap.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid_i = 1; in_data_i = 8'(i);
      tick();
    end
    in_valid_i = 0;
    repeat (3) tick();
    errs = 0;
    for (int i = 0; i < 20; i++) if (i >= cap.size() || cap[i] !== 8'(i)) errs++;
    check("stream_count", 32'(cap.size()), 20);
    check("stream_order_errs", 32'(errs), 0);

    // Backpressure.
    do_reset();
    cap.delete();
    full_i = 1;
    in_valid_i = 1; in_data_i = 8'h11; tick();
    in_data_i = 8'h22; tick();
    in_data_i = 8'h33; tick();
    @(negedge wclk);
    check("bp_buf", 32'(buf_count_o), 2);
    check("bp_ready", 32'(in_ready_o), 0);
    check("bp_winc", 32'(winc_o), 0);
    tick();
    full_i = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge wclk);
      rdy = in_ready_o;
      tick();
      got = rdy;
    end
    check("bp_accept_timeout", 32'(got), 1);
    in_valid_i = 0;
    repeat (4) tick();
    check("bp_count", 32'(cap.size()), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order", (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));

    // Full toggling under continuous input.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      full_i = (i % 2 == 0);
      in_valid_i = 1; in_data_i = 8'($urandom);
      tick();
    end
    in_valid_i = 0; full_i = 0;
    repeat (3) tick();

    // Level wrap: 17 pops leave wcnt = 1; rbin 1011 gives level 6.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid_i = 1; in_data_i = 8'(i);
      tick();
    end
    in_valid_i = 0;
    repeat (2) tick();
    set_rptr(11);
    check("gray_1011", 32'(syn_rptr_i), 32'h E);
    tick();
    @(negedge wclk);
    check("wrap_level", 32'(wr_level_o), 6);
    check("wrap_af", 32'(almost_full_o), 1);
    tick();
    set_rptr(0);
    tick();
    @(negedge wclk);
    check("wrap_level0", 32'(wr_level_o), 1);
    check("wrap_af0", 32'(almost_full_o), 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      in_valid_i = ($urandom_range(0, 3) != 0);
      in_data_i  = 8'($urandom);
      full_i     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) set_rptr(int'($urandom_range(0, PMOD - 1)));
      tick();
    end
    in_valid_i = 0; full_i = 0;
    repeat (3) tick();

    // Async reset while holding two words.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1; in_data_i = 8'(8'h40 + i); tick();
    end
    full_i = 1;
    in_data_i = 8'h50; tick();
    in_data_i = 8'h51; tick();
    in_valid_i = 0;
    @(negedge wclk);
    check("pre_rst_buf", 32'(buf_count_o), 2);
    #1 full_i = 0;
    #1 wrst_n = 0;
    #1;
    check("arst_winc", 32'(winc_o), 0);
    check("arst_buf", 32'(buf_count_o), 0);
    check("arst_level", 32'(wr_level_o), 0);
    check("arst_af", 32'(almost_full_o), 0);
    check("arst_ready", 32'(in_ready_o), 0);
    @(negedge wclk);
    #1 wrst_n = 1;
    tick();
    in_valid_i = 1; in_data_i = 8'h5A;
    tick();
    in_valid_i = 0;
    @(negedge wclk);
    check("post_rst_winc", 32'(winc_o), 1);
    check("post_rst_wdata", 32'(wdata_o), 32'h5A);
    tick();
    @(negedge wclk);
    check("post_rst_winc_off", 32'(winc_o), 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
